// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: one-cycle capture of decoded state with freeze, flush,
// WB operand bypass/refresh and saturating stall/bubble counters.
module id_ex_stage_reg #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SHOP_W  = 12,
  parameter int unsigned REG_A_W = 4,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [WORD_W-1:0]  id_pc,
  input  logic               id_wb_en,
  input  logic               id_mem_r_en,
  input  logic               id_mem_w_en,
  input  logic               id_b,
  input  logic               id_s,
  input  logic [CMD_W-1:0]   id_exe_cmd,
  input  logic [WORD_W-1:0]  id_val_rn,
  input  logic [WORD_W-1:0]  id_val_rm,
  input  logic [REG_A_W-1:0] id_src1,
  input  logic [REG_A_W-1:0] id_src2,
  input  logic               id_use_src2,
  input  logic               id_imm,
  input  logic [SHOP_W-1:0]  id_shift_operand,
  input  logic [23:0]        id_simm24,
  input  logic [REG_A_W-1:0] id_dest,
  input  logic [3:0]         id_status,
  input  logic               wb_wr_en,
  input  logic [REG_A_W-1:0] wb_dest,
  input  logic [WORD_W-1:0]  wb_value,
  output logic               ex_valid,
  output logic [WORD_W-1:0]  ex_pc,
  output logic               ex_wb_en,
  output logic               ex_mem_r_en,
  output logic               ex_mem_w_en,
  output logic               ex_b,
  output logic               ex_s,
  output logic [CMD_W-1:0]   ex_exe_cmd,
  output logic [WORD_W-1:0]  ex_val_rn,
  output logic [WORD_W-1:0]  ex_val_rm,
  output logic [REG_A_W-1:0] ex_src1,
  output logic [REG_A_W-1:0] ex_src2,
  output logic               ex_use_src2,
  output logic               ex_imm,
  output logic [SHOP_W-1:0]  ex_shift_operand,
  output logic [23:0]        ex_simm24,
  output logic [REG_A_W-1:0] ex_dest,
  output logic [3:0]         ex_status,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Control bits that must never leak from a bubble: {wb_en, mem_r_en, mem_w_en, b, s}
  logic               valid_q, valid_d;
  logic [WORD_W-1:0]  pc_q, pc_d;
  logic [4:0]         ctl_q, ctl_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [WORD_W-1:0]  rn_q, rn_d;
  logic [WORD_W-1:0]  rm_q, rm_d;
  logic [REG_A_W-1:0] src1_q, src1_d;
  logic [REG_A_W-1:0] src2_q, src2_d;
  logic               use2_q, use2_d;
  logic               imm_q, imm_d;
  logic [SHOP_W-1:0]  shop_q, shop_d;
  logic [23:0]        simm_q, simm_d;
  logic [REG_A_W-1:0] dest_q, dest_d;
  logic [3:0]         status_q, status_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;

  logic [4:0] id_ctl;
  assign id_ctl = {id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s};

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    ctl_d    = ctl_q;
    cmd_d    = cmd_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    use2_d   = use2_q;
    imm_d    = imm_q;
    shop_d   = shop_q;
    simm_d   = simm_q;
    dest_d   = dest_q;
    status_d = status_q;
    stall_d  = stall_q;
    bubble_d = bubble_q;

    if (flush) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      ctl_d    = '0;
      cmd_d    = '0;
      rn_d     = '0;
      rm_d     = '0;
      src1_d   = '0;
      src2_d   = '0;
      use2_d   = 1'b0;
      imm_d    = 1'b0;
      shop_d   = '0;
      simm_d   = '0;
      dest_d   = '0;
      status_d = '0;
      if (bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
    end else if (freeze) begin
      // Held operands track WB writes so the stalled instruction sees fresh values
      if (valid_q) begin
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (wb_wr_en && (wb_dest == src1_q)) rn_d = wb_value;
        if (wb_wr_en && use2_q && (wb_dest == src2_q)) rm_d = wb_value;
      end
    end else begin
      valid_d  = id_valid;
      pc_d     = id_pc;
      ctl_d    = id_valid ? id_ctl : 5'b0;
      cmd_d    = id_exe_cmd;
      rn_d     = (wb_wr_en && (wb_dest == id_src1)) ? wb_value : id_val_rn;
      rm_d     = (wb_wr_en && id_use_src2 && (wb_dest == id_src2)) ? wb_value : id_val_rm;
      src1_d   = id_src1;
      src2_d   = id_src2;
      use2_d   = id_use_src2;
      imm_d    = id_imm;
      shop_d   = id_shift_operand;
      simm_d   = id_simm24;
      dest_d   = id_dest;
      status_d = id_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ctl_q    <= '0;
      cmd_q    <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      use2_q   <= 1'b0;
      imm_q    <= 1'b0;
      shop_q   <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
      status_q <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      ctl_q    <= ctl_d;
      cmd_q    <= cmd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      use2_q   <= use2_d;
      imm_q    <= imm_d;
      shop_q   <= shop_d;
      simm_q   <= simm_d;
      dest_q   <= dest_d;
      status_q <= status_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_pc            = pc_q;
  assign ex_wb_en         = ctl_q[4];
  assign ex_mem_r_en      = ctl_q[3];
  assign ex_mem_w_en      = ctl_q[2];
  assign ex_b             = ctl_q[1];
  assign ex_s             = ctl_q[0];
  assign ex_exe_cmd       = cmd_q;
  assign ex_val_rn        = rn_q;
  assign ex_val_rm        = rm_q;
  assign ex_src1          = src1_q;
  assign ex_src2          = src2_q;
  assign ex_use_src2      = use2_q;
  assign ex_imm           = imm_q;
  assign ex_shift_operand = shop_q;
  assign ex_simm24        = simm_q;
  assign ex_dest          = dest_q;
  assign ex_status        = status_q;
  assign stall_cnt        = stall_q;
  assign bubble_cnt       = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed vectors push expected output snapshots,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  ctl;     // {wb_en, mem_r_en, mem_w_en, b, s}
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        use2;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic [15:0] stall;
    logic [15:0] bubble;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze, flush, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm, wb_value;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
  logic [3:0]  id_exe_cmd, id_src1, id_src2, id_dest, id_status, wb_dest;
  logic        id_use_src2, id_imm, wb_wr_en;
  logic [11:0] id_shift_operand;
  logic [23:0] id_simm24;

  logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_use_src2, ex_imm;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [3:0]  ex_exe_cmd, ex_src1, ex_src2, ex_dest, ex_status;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_simm24;
  logic [15:0] stall_cnt, bubble_cnt;

  snap_t e;
  snap_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_imm(id_imm), .id_shift_operand(id_shift_operand),
    .id_simm24(id_simm24), .id_dest(id_dest), .id_status(id_status),
    .wb_wr_en(wb_wr_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd),
    .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_use_src2(ex_use_src2), .ex_imm(ex_imm), .ex_shift_operand(ex_shift_operand),
    .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_status(ex_status),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Monitor: one pending expectation is consumed per clock edge or reset assertion
  initial begin
    snap_t act, want;
    string nm;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        act  = {ex_valid, ex_pc, {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s}, ex_exe_cmd,
                ex_val_rn, ex_val_rm, ex_src1, ex_src2, ex_use_src2, ex_imm,
                ex_shift_operand, ex_simm24, ex_dest, ex_status, stall_cnt, bubble_cnt};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, want);
        end
      end
    end
  end

  task automatic clr_in();
    freeze = 0; flush = 0; wb_wr_en = 0; wb_dest = 0; wb_value = 0;
    id_valid = 0; id_pc = 0; id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; id_b = 0;
    id_s = 0; id_exe_cmd = 0; id_val_rn = 0; id_val_rm = 0; id_src1 = 0; id_src2 = 0;
    id_use_src2 = 0; id_imm = 0; id_shift_operand = 0; id_simm24 = 0; id_dest = 0;
    id_status = 0;
  endtask

  task automatic push_step(input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    e = '0;
    @(negedge clk);
    push_step("reset_state");
    rst_n = 1;
    push_step("idle_after_reset");

    // Main load
    id_valid = 1; id_pc = 32'h104; id_exe_cmd = 4'b0010; id_val_rm = 32'hF0;
    id_wb_en = 1; id_s = 1; id_src1 = 3; id_val_rn = 32'h55; id_src2 = 7; id_use_src2 = 1;
    id_imm = 1; id_shift_operand = 12'hABC; id_simm24 = 24'h123456; id_dest = 9;
    id_status = 4'hA;
    e.valid = 1; e.pc = 32'h104; e.ctl = 5'b10001; e.cmd = 4'd2; e.rn = 32'h55;
    e.rm = 32'hF0; e.src1 = 3; e.src2 = 7; e.use2 = 1; e.imm = 1; e.shop = 12'hABC;
    e.simm = 24'h123456; e.dest = 9; e.status = 4'hA;
    push_step("load");

    // Stall refresh of Rn, then Rm, then a non-matching WB write
    id_pc = 32'h999; id_val_rn = 32'h777; id_exe_cmd = 4'hF;
    freeze = 1; wb_wr_en = 1; wb_dest = 3; wb_value = 32'hDEAD;
    e.rn = 32'hDEAD; e.stall = 1;
    push_step("stall_refresh_rn");
    wb_dest = 7; wb_value = 32'hBEEF;
    e.rm = 32'hBEEF; e.stall = 2;
    push_step("stall_refresh_rm");
    wb_dest = 4; wb_value = 32'h1234;
    e.stall = 3;
    push_step("stall_no_match");

    // Flush wins over freeze
    flush = 1;
    e = '0; e.stall = 3; e.bubble = 1;
    push_step("flush_over_freeze");

    // Freeze with an empty slot: no stall count, no refresh
    flush = 0; wb_dest = 0; wb_value = 32'h5;
    push_step("freeze_invalid");

    // Load of a non-valid slot masks controls but keeps data
    clr_in();
    id_wb_en = 1; id_mem_r_en = 1; id_b = 1; id_pc = 32'h200; id_exe_cmd = 4'd5;
    e.pc = 32'h200; e.cmd = 4'd5;
    push_step("load_invalid_masks_ctl");

    // Load bypass on Rm, honouring use_src2
    clr_in();
    id_valid = 1; id_mem_w_en = 1; id_src1 = 2; id_val_rn = 32'h33; id_src2 = 5;
    id_use_src2 = 1; id_val_rm = 32'h11; wb_wr_en = 1; wb_dest = 5; wb_value = 32'h22;
    e = '0; e.stall = 3; e.bubble = 1;
    e.valid = 1; e.ctl = 5'b00100; e.src1 = 2; e.rn = 32'h33; e.src2 = 5; e.use2 = 1;
    e.rm = 32'h22;
    push_step("bypass_rm");
    id_use_src2 = 0;
    e.use2 = 0; e.rm = 32'h11;
    push_step("bypass_rm_unused");
    wb_dest = 2; wb_value = 32'h44;
    e.rn = 32'h44;
    push_step("bypass_rn");

    // src1 == src2: one WB write refreshes both held operands
    wb_wr_en = 0; id_src1 = 8; id_src2 = 8; id_use_src2 = 1; id_val_rn = 1; id_val_rm = 2;
    e.src1 = 8; e.src2 = 8; e.use2 = 1; e.rn = 1; e.rm = 2;
    push_step("load_same_src");
    freeze = 1; wb_wr_en = 1; wb_dest = 8; wb_value = 32'h99; id_pc = 32'hFFF;
    e.rn = 32'h99; e.rm = 32'h99; e.stall = 4;
    push_step("stall_refresh_both");

    clr_in();
    flush = 1;
    e = '0; e.stall = 4; e.bubble = 2;
    push_step("flush_alone");

    // Asynchronous reset while a valid instruction is held
    clr_in();
    id_valid = 1; id_pc = 32'h104; id_b = 1;
    e.valid = 1; e.pc = 32'h104; e.ctl = 5'b00010;
    push_step("load_before_reset");
    e = '0;
    exp_q.push_back(e);
    name_q.push_back("async_reset_midstream");
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    // Stall counter saturation
    clr_in();
    id_valid = 1;
    e = '0; e.valid = 1;
    push_step("sat_load");
    freeze = 1;
    repeat (65533) @(negedge clk);
    e.stall = 16'hFFFE;
    push_step("stall_fffe");
    e.stall = 16'hFFFF;
    push_step("stall_ffff");
    push_step("stall_sat_hold1");
    push_step("stall_sat_hold2");

    clr_in();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
